// File: rtl/mem_arb_pkg.sv
// Shared types for the N-source memory arbiter: op encoding, arbitration
// mode selectors and the arbiter FSM state.
// Pure declarations; no logic, no latency, no flow control.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10
    } mem_op_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BUSY    = 2'b01,
        ST_RELEASE = 2'b10
    } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection: round-robin search from rr_ptr, or lowest-index with aged requesters first.
// Purely combinational, zero latency.
// No flow control; win_vld simply reports that at least one request is present.
//
// Ports: req/aged (per-source request and starvation flags), rr_ptr (search start),
//        rr_mode (1 = round-robin), win_idx/win_vld (selected source, any-request flag).
module mem_arb_pick #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    input  logic [NUM_SRC-1:0] aged,
    input  logic               rr_mode,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_vld
);

    logic [NUM_SRC-1:0] cand;
    logic [IDX_W:0]     sum;
    logic               found;

    always_comb begin
        win_idx = '0;
        found   = 1'b0;
        sum     = '0;
        // Aged requesters, when any exist, pre-empt plain priority order.
        cand    = (|(req & aged)) ? (req & aged) : req;
        if (rr_mode) begin
            for (int off = 0; off < NUM_SRC; off++) begin
                // rr_ptr < NUM_SRC, so a single subtraction wraps the search.
                sum = {1'b0, rr_ptr} + (IDX_W+1)'(off);
                if (sum >= (IDX_W+1)'(NUM_SRC)) begin
                    sum = sum - (IDX_W+1)'(NUM_SRC);
                end
                if (!found && req[sum[IDX_W-1:0]]) begin
                    found   = 1'b1;
                    win_idx = sum[IDX_W-1:0];
                end
            end
        end else begin
            // Descending scan leaves the lowest set index as the winner.
            for (int i = NUM_SRC - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    win_idx = IDX_W'(i);
                end
            end
        end
        win_vld = |req;
    end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-source arbiter in front of the single mem_ctrl port; one grant is held per transaction.
// Latency: request in IDLE at cycle t -> op/address/data registered downstream at t+1.
// Backpressure: a source holds its op until its tx_done_src; losers simply wait in place.
//
// Ports: op_src/raw_address_src/common_data_bus_read_in_src are per-source request slices;
//        tx_done_src/rd_valid_src route completions to the grantee only; read data is
//        broadcast on common_data_bus_write_out_src. op/raw_address/common_data_bus_read_in
//        and tx_done/rd_valid/common_data_bus_write_out face mem_ctrl; grant_id/busy are status.
module mem_arbiter_n #(
    parameter int NUM_SRC    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 512,
    parameter int ARB_MODE   = 0,
    parameter int AGE_LIMIT  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [2*NUM_SRC-1:0]          op_src,
    input  logic [ADDR_WIDTH*NUM_SRC-1:0] raw_address_src,
    input  logic [DATA_WIDTH*NUM_SRC-1:0] common_data_bus_read_in_src,
    output logic [DATA_WIDTH*NUM_SRC-1:0] common_data_bus_write_out_src,
    output logic [NUM_SRC-1:0]            tx_done_src,
    output logic [NUM_SRC-1:0]            rd_valid_src,
    input  logic [DATA_WIDTH-1:0]         common_data_bus_write_out,
    input  logic                          tx_done,
    input  logic                          rd_valid,
    output logic [1:0]                    op,
    output logic [ADDR_WIDTH-1:0]         raw_address,
    output logic [DATA_WIDTH-1:0]         common_data_bus_read_in,
    output logic [$clog2(NUM_SRC)-1:0]    grant_id,
    output logic                          busy
);
    import mem_arb_pkg::*;

    localparam int IDX_W   = $clog2(NUM_SRC);
    localparam int AGE_W   = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);
    localparam bit   RR_MODE = (ARB_MODE == ARB_RR);
    localparam bit   USE_AGE = (ARB_MODE == ARB_FIXED) && (AGE_LIMIT > 0);

    arb_state_t              state_q, state_d;
    mem_op_t                 op_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdat_q;
    logic [IDX_W-1:0]        grant_q;
    logic [IDX_W-1:0]        rr_ptr_q;
    logic [AGE_W-1:0]        age_q [NUM_SRC];

    logic [NUM_SRC-1:0]      req;
    logic [NUM_SRC-1:0]      aged;
    logic [IDX_W-1:0]        win_idx;
    logic                    win_vld;
    mem_op_t                 win_op;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0]   win_dat;

    // Op code 11 is not a request.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            req[i]  = (op_src[2*i +: 2] == OP_READ) || (op_src[2*i +: 2] == OP_WRITE);
            aged[i] = USE_AGE && (age_q[i] == AGE_MAX);
        end
    end

    mem_arb_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .aged    (aged),
        .rr_mode (RR_MODE),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    always_comb begin
        win_op   = OP_NOP;
        win_addr = '0;
        win_dat  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_op   = mem_op_t'(op_src[2*i +: 2]);
                win_addr = raw_address_src[ADDR_WIDTH*i +: ADDR_WIDTH];
                win_dat  = common_data_bus_read_in_src[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    // RELEASE gives the finished source one cycle to drop its op so it is not re-granted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (win_vld) state_d = ST_BUSY;
            ST_BUSY:    if (tx_done) state_d = ST_RELEASE;
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_NOP;
            addr_q   <= '0;
            wdat_q   <= '0;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && win_vld) begin
                op_q    <= win_op;
                addr_q  <= win_addr;
                wdat_q  <= win_dat;
                grant_q <= win_idx;
                if (RR_MODE) begin
                    rr_ptr_q <= (win_idx == IDX_W'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;
                end
            end else if (state_q == ST_BUSY && tx_done) begin
                op_q <= OP_NOP;
            end
            // Ages move only on arbitration cycles; a requester implies a grant this cycle.
            if (USE_AGE && state_q == ST_IDLE) begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (!req[i] || win_idx == IDX_W'(i)) begin
                        age_q[i] <= '0;
                    end else if (age_q[i] != AGE_MAX) begin
                        age_q[i] <= age_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign op                      = op_q;
    assign raw_address             = addr_q;
    assign common_data_bus_read_in = wdat_q;
    assign grant_id                = grant_q;
    assign busy                    = (state_q == ST_BUSY);

    always_comb begin
        tx_done_src           = '0;
        rd_valid_src          = '0;
        tx_done_src[grant_q]  = tx_done & busy;
        rd_valid_src[grant_q] = rd_valid & busy;
    end

    assign common_data_bus_write_out_src = {NUM_SRC{common_data_bus_write_out}};

endmodule

// File: tb/tb_mem_arbiter_n.sv
module tb_mem_arbiter_n;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [2*NS-1:0]     op_src;
    logic [AW*NS-1:0]    addr_src;
    logic [DW*NS-1:0]    wd_src;
    logic [DW-1:0]       rdata;
    logic                tx_done;
    logic                rd_valid;

    // Instance 0: fixed, AGE_LIMIT=2; instance 1: fixed, no aging; instance 2: round-robin.
    logic [NS*DW-1:0]    rdo  [3];
    logic [NS-1:0]       txs  [3];
    logic [NS-1:0]       rvs  [3];
    logic [1:0]          opo  [3];
    logic [AW-1:0]       ao   [3];
    logic [DW-1:0]       wo   [3];
    logic [1:0]          gid  [3];
    logic                bsy  [3];

    logic [1:0]          s_op   [NS];
    logic [AW-1:0]       s_addr [NS];
    logic [DW-1:0]       s_dat  [NS];

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            op_src[2*i +: 2]     = s_op[i];
            addr_src[AW*i +: AW] = s_addr[i];
            wd_src[DW*i +: DW]   = s_dat[i];
        end
    end

    mem_arbiter_n #(.NUM_SRC(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(0), .AGE_LIMIT(2)) u_fix2 (
        .clk(clk), .rst_n(rst_n), .op_src(op_src), .raw_address_src(addr_src),
        .common_data_bus_read_in_src(wd_src), .common_data_bus_write_out_src(rdo[0]),
        .tx_done_src(txs[0]), .rd_valid_src(rvs[0]), .common_data_bus_write_out(rdata),
        .tx_done(tx_done), .rd_valid(rd_valid), .op(opo[0]), .raw_address(ao[0]),
        .common_data_bus_read_in(wo[0]), .grant_id(gid[0]), .busy(bsy[0]));

    mem_arbiter_n #(.NUM_SRC(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(0), .AGE_LIMIT(0)) u_fix0 (
        .clk(clk), .rst_n(rst_n), .op_src(op_src), .raw_address_src(addr_src),
        .common_data_bus_read_in_src(wd_src), .common_data_bus_write_out_src(rdo[1]),
        .tx_done_src(txs[1]), .rd_valid_src(rvs[1]), .common_data_bus_write_out(rdata),
        .tx_done(tx_done), .rd_valid(rd_valid), .op(opo[1]), .raw_address(ao[1]),
        .common_data_bus_read_in(wo[1]), .grant_id(gid[1]), .busy(bsy[1]));

    mem_arbiter_n #(.NUM_SRC(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(1), .AGE_LIMIT(8)) u_rr (
        .clk(clk), .rst_n(rst_n), .op_src(op_src), .raw_address_src(addr_src),
        .common_data_bus_read_in_src(wd_src), .common_data_bus_write_out_src(rdo[2]),
        .tx_done_src(txs[2]), .rd_valid_src(rvs[2]), .common_data_bus_write_out(rdata),
        .tx_done(tx_done), .rd_valid(rd_valid), .op(opo[2]), .raw_address(ao[2]),
        .common_data_bus_read_in(wo[2]), .grant_id(gid[2]), .busy(bsy[2]));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_done = 0;
    int sel     = 0;
    int m_age [NS];
    int m_rr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- reference model (arbitration rules) ----------------
    function automatic int age_lim();
        return (sel == 0) ? 2 : 0;
    endfunction

    function automatic bit [NS-1:0] req_vec();
        bit [NS-1:0] r;
        for (int i = 0; i < NS; i++) r[i] = (s_op[i] == 2'b01) || (s_op[i] == 2'b10);
        return r;
    endfunction

    function automatic int model_pick(input bit [NS-1:0] r);
        if (sel == 2) begin
            for (int k = 0; k < NS; k++)
                if (r[(m_rr + k) % NS]) return (m_rr + k) % NS;
            return -1;
        end
        if (age_lim() > 0)
            for (int i = 0; i < NS; i++)
                if (r[i] && m_age[i] == age_lim()) return i;
        for (int i = 0; i < NS; i++)
            if (r[i]) return i;
        return -1;
    endfunction

    function automatic void model_grant(input int w, input bit [NS-1:0] r);
        if (sel == 2) begin
            m_rr = (w + 1) % NS;
        end else if (age_lim() > 0) begin
            for (int i = 0; i < NS; i++) begin
                if (i == w || !r[i]) m_age[i] = 0;
                else if (m_age[i] < age_lim()) m_age[i] = m_age[i] + 1;
            end
        end
    endfunction

    function automatic void model_idle();
        for (int i = 0; i < NS; i++) if (!req_vec()[i]) m_age[i] = 0;
    endfunction

    function automatic void model_reset();
        m_rr = 0;
        for (int i = 0; i < NS; i++) m_age[i] = 0;
    endfunction

    task automatic clear_src();
        for (int i = 0; i < NS; i++) begin
            s_op[i] = 2'b00; s_addr[i] = '0; s_dat[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tx_done = 1'b0; rd_valid = 1'b0;
        clear_src();
        tick(); tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    // One full transaction from grant to back-in-IDLE, checked against the model.
    task automatic run_txn(input int lat, input bit rd_end, input bit stale, input bit mutate,
                           output int gid_got, output int gap);
        bit [NS-1:0]   r;
        int            w;
        logic [1:0]    e_op;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d;
        logic [NS-1:0] onehot;
        r = req_vec();
        w = model_pick(r);
        gid_got = -1;
        gap = 0;
        if (w < 0) begin
            n_tests++; n_fail++;
            $display("FAIL setup: no requesting source, required at least one");
            return;
        end
        e_op = s_op[w]; e_a = s_addr[w]; e_d = s_dat[w];
        onehot = NS'(1) << w;
        tick();
        gap = cyc - last_done;
        gid_got = int'(gid[sel]);
        model_grant(w, r);
        n_tests++;
        if (bsy[sel] !== 1'b1 || gid[sel] !== 2'(w)) begin
            n_fail++;
            $display("FAIL grant: busy=%0b grant_id=%0d, required busy=1 grant_id=%0d", bsy[sel], gid[sel], w);
        end
        n_tests++;
        if (opo[sel] !== e_op || ao[sel] !== e_a || wo[sel] !== e_d) begin
            n_fail++;
            $display("FAIL issue: op=%0d addr=%h data=%h, required op=%0d addr=%h data=%h",
                     opo[sel], ao[sel], wo[sel], e_op, e_a, e_d);
        end
        for (int i = 0; i < lat; i++) begin
            if (mutate) begin
                for (int j = 0; j < NS; j++) begin
                    s_addr[j] = $urandom;
                    s_dat[j]  = {$urandom, $urandom};
                end
            end
            rd_valid = mutate ? 1'($urandom_range(0, 1)) : 1'b0;
            rdata = {$urandom, $urandom};
            #1;
            n_tests++;
            if (opo[sel] !== e_op || ao[sel] !== e_a || wo[sel] !== e_d) begin
                n_fail++;
                $display("FAIL hold: op=%0d addr=%h data=%h, required op=%0d addr=%h data=%h",
                         opo[sel], ao[sel], wo[sel], e_op, e_a, e_d);
            end
            n_tests++;
            if (txs[sel] !== '0 || rvs[sel] !== (rd_valid ? onehot : '0) || rdo[sel] !== {NS{rdata}}) begin
                n_fail++;
                $display("FAIL busy_route: tx_done_src=%b rd_valid_src=%b rdout=%h, required %b %b %h",
                         txs[sel], rvs[sel], rdo[sel], 4'b0, (rd_valid ? onehot : 4'b0), {NS{rdata}});
            end
            tick();
        end
        rd_valid = rd_end;
        tx_done  = 1'b1;
        rdata    = {$urandom, $urandom};
        #1;
        n_tests++;
        if (txs[sel] !== onehot || rvs[sel] !== (rd_end ? onehot : '0) || rdo[sel] !== {NS{rdata}}) begin
            n_fail++;
            $display("FAIL done_route: tx_done_src=%b rd_valid_src=%b, required %b %b",
                     txs[sel], rvs[sel], onehot, (rd_end ? onehot : 4'b0));
        end
        last_done = cyc;
        tick();
        tx_done = 1'b0; rd_valid = 1'b0;
        if (!stale) s_op[w] = 2'b00;
        n_tests++;
        if (opo[sel] !== 2'b00 || bsy[sel] !== 1'b0) begin
            n_fail++;
            $display("FAIL release: op=%0d busy=%0b, required op=0 busy=0", opo[sel], bsy[sel]);
        end
        tick();
        s_op[w] = 2'b00;
        n_tests++;
        if (opo[sel] !== 2'b00 || bsy[sel] !== 1'b0) begin
            n_fail++;
            $display("FAIL idle: op=%0d busy=%0b, required op=0 busy=0", opo[sel], bsy[sel]);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        clear_src();
        s_op[0] = 2'b01; s_addr[0] = 32'hDEAD_BEEF; s_dat[0] = 64'h1234;
        tx_done = 1'b1; rd_valid = 1'b1;
        tick(); tick();
        #1;
        for (int s = 0; s < 3; s++) begin
            n_tests++;
            if (opo[s] !== 2'b00 || bsy[s] !== 1'b0 || gid[s] !== 2'd0 || ao[s] !== '0 || wo[s] !== '0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: op=%0d busy=%0b gid=%0d addr=%h data=%h, required all 0",
                         s, opo[s], bsy[s], gid[s], ao[s], wo[s]);
            end
            n_tests++;
            if (txs[s] !== '0 || rvs[s] !== '0) begin
                n_fail++;
                $display("FAIL reset_route[%0d]: tx_done_src=%b rd_valid_src=%b, required 0000 0000", s, txs[s], rvs[s]);
            end
        end
        tx_done = 1'b0; rd_valid = 1'b0;
        rst_n = 1'b1;
        clear_src();
        model_reset();
        tick();
    endtask

    task automatic test_single_read();
        int g, gap;
        sel = 0; do_reset();
        s_op[2] = 2'b01; s_addr[2] = 32'h6000_0040; s_dat[2] = 64'h0;
        run_txn(4, 1'b1, 1'b0, 1'b0, g, gap);
        n_tests++;
        if (g !== 2) begin
            n_fail++;
            $display("FAIL single_read_gid: grant_id=%0d, required 2", g);
        end
    endtask

    task automatic test_fixed_contention();
        int g, gap;
        int exp_a2 [6] = '{0, 0, 3, 0, 0, 3};
        sel = 1; do_reset();
        for (int k = 0; k < 4; k++) begin
            s_op[0] = 2'b01; s_op[3] = 2'b10;
            s_addr[0] = $urandom; s_addr[3] = $urandom;
            run_txn($urandom_range(0, 2), 1'b0, 1'b0, 1'b0, g, gap);
            n_tests++;
            if (g !== 0) begin
                n_fail++;
                $display("FAIL contention_noage[%0d]: grant_id=%0d, required 0", k, g);
            end
        end
        sel = 0; do_reset();
        for (int k = 0; k < 6; k++) begin
            s_op[0] = 2'b01; s_op[3] = 2'b10;
            s_addr[0] = $urandom; s_addr[3] = $urandom;
            run_txn($urandom_range(0, 2), 1'b0, 1'b0, 1'b0, g, gap);
            n_tests++;
            if (g !== exp_a2[k]) begin
                n_fail++;
                $display("FAIL contention_age2[%0d]: grant_id=%0d, required %0d", k, g, exp_a2[k]);
            end
        end
        clear_src();
    endtask

    task automatic test_round_robin();
        int g, gap;
        int exp_rr [5] = '{0, 1, 2, 3, 0};
        sel = 2; do_reset();
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < NS; i++) begin
                s_op[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
                s_addr[i] = $urandom;
            end
            run_txn($urandom_range(0, 3), 1'b1, 1'b0, 1'b1, g, gap);
            n_tests++;
            if (g !== exp_rr[k]) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: grant_id=%0d, required %0d", k, g, exp_rr[k]);
            end
            if (k > 0) begin
                n_tests++;
                if (gap !== 3) begin
                    n_fail++;
                    $display("FAIL rr_gap[%0d]: next op %0d cycles after tx_done, required 3", k, gap);
                end
            end
        end
        clear_src();
    endtask

    task automatic test_write_hold();
        int g, gap;
        sel = 0; do_reset();
        s_op[1] = 2'b10; s_addr[1] = 32'h0000_1100; s_dat[1] = 64'hA5A5_A5A5_A5A5_A5A5;
        run_txn(4, 1'b0, 1'b0, 1'b1, g, gap);
        n_tests++;
        if (g !== 1) begin
            n_fail++;
            $display("FAIL write_gid: grant_id=%0d, required 1", g);
        end
    endtask

    task automatic test_stale();
        int g, gap;
        sel = 0; do_reset();
        tx_done = 1'b1; rd_valid = 1'b1;
        #1;
        n_tests++;
        if (txs[sel] !== '0 || rvs[sel] !== '0) begin
            n_fail++;
            $display("FAIL unsolicited_route: tx_done_src=%b rd_valid_src=%b, required 0000 0000", txs[sel], rvs[sel]);
        end
        tick();
        tx_done = 1'b0; rd_valid = 1'b0;
        n_tests++;
        if (bsy[sel] !== 1'b0 || opo[sel] !== 2'b00) begin
            n_fail++;
            $display("FAIL unsolicited_state: busy=%0b op=%0d, required 0 0", bsy[sel], opo[sel]);
        end
        model_idle();
        s_op[1] = 2'b01; s_addr[1] = 32'h0000_0A00;
        run_txn(2, 1'b1, 1'b1, 1'b0, g, gap);
        tick();
        model_idle();
        n_tests++;
        if (bsy[sel] !== 1'b0 || opo[sel] !== 2'b00) begin
            n_fail++;
            $display("FAIL stale_regrant: busy=%0b op=%0d, required 0 0", bsy[sel], opo[sel]);
        end
        s_op[2] = 2'b10; s_dat[2] = 64'h0F0F;
        run_txn(1, 1'b0, 1'b0, 1'b0, g, gap);
        n_tests++;
        if (g !== 2) begin
            n_fail++;
            $display("FAIL after_stale_gid: grant_id=%0d, required 2", g);
        end
    endtask

    task automatic test_reset_mid_busy();
        int g, gap;
        sel = 2; do_reset();
        s_op[1] = 2'b01;
        run_txn(1, 1'b0, 1'b0, 1'b0, g, gap);
        s_op[1] = 2'b01; s_addr[1] = 32'h5555_0000;
        tick();
        n_tests++;
        if (bsy[sel] !== 1'b1 || gid[sel] !== 2'd1) begin
            n_fail++;
            $display("FAIL pre_reset_grant: busy=%0b grant_id=%0d, required 1 1", bsy[sel], gid[sel]);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        s_op[1] = 2'b00;
        tx_done = 1'b1;
        #1;
        n_tests++;
        if (opo[sel] !== 2'b00 || bsy[sel] !== 1'b0 || gid[sel] !== 2'd0 || txs[sel] !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: op=%0d busy=%0b gid=%0d tx_done_src=%b, required 0 0 0 0000",
                     opo[sel], bsy[sel], gid[sel], txs[sel]);
        end
        tick();
        tx_done = 1'b0;
        model_reset();
        s_op[0] = 2'b01; s_op[3] = 2'b10;
        run_txn(1, 1'b1, 1'b0, 1'b0, g, gap);
        n_tests++;
        if (g !== 0) begin
            n_fail++;
            $display("FAIL post_reset_rr: grant_id=%0d, required 0", g);
        end
        clear_src();
    endtask

    task automatic test_random();
        int g, gap;
        for (int s = 0; s < 3; s++) begin
            sel = s; do_reset();
            for (int k = 0; k < 15; k++) begin
                for (int i = 0; i < NS; i++) begin
                    if ((s_op[i] == 2'b00 || s_op[i] == 2'b11) && $urandom_range(0, 1) == 1) begin
                        s_op[i]   = 2'($urandom_range(0, 3));
                        s_addr[i] = $urandom;
                        s_dat[i]  = {$urandom, $urandom};
                    end
                end
                if (req_vec() == '0) s_op[$urandom_range(0, NS - 1)] = 2'b01;
                run_txn($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, g, gap);
            end
            clear_src();
        end
    endtask

    initial begin
        rst_n = 1'b0; tx_done = 1'b0; rd_valid = 1'b0; rdata = '0;
        clear_src();
        model_reset();
        test_reset();
        test_single_read();
        test_fixed_contention();
        test_round_robin();
        test_write_hold();
        test_stale();
        test_reset_mid_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter_n.md
Name: mem_arbiter_n

Overview:
- Parametrised N-source arbiter for the single mem_ctrl port.
- Generalises the fixed 4-source memory arbiter to NUM_SRC sources with configurable address/data widths.
- Selectable fixed-priority or round-robin mode; fixed-priority mode has starvation aging.
- Holds one grant for a whole transaction, from op issue to tx_done. Routes tx_done and rd_valid only to the granted source.

Parameters:
- NUM_SRC, 4: number of requesting sources (2..16).
- ADDR_WIDTH, 32: raw_address width.
- DATA_WIDTH, 512: cache-line data bus width.
- ARB_MODE, 0: 0 = fixed priority (src 0 highest); 1 = round-robin.
- AGE_LIMIT, 8: fixed-mode starvation threshold in lost grants; 0 disables aging.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: synchronous, active-low.
- op_src  in  2*NUM_SRC  per-source op: 00 NOP, 01 READ, 10 WRITE, 11 treated as NOP.
- raw_address_src  in  ADDR_WIDTH*NUM_SRC  per-source address.
- common_data_bus_read_in_src  in  DATA_WIDTH*NUM_SRC  per-source write data.
- common_data_bus_write_out_src  out  DATA_WIDTH*NUM_SRC  read data, broadcast to every source.
- tx_done_src  out  NUM_SRC  per-source completion.
- rd_valid_src  out  NUM_SRC  per-source read-data valid.
- common_data_bus_write_out  in  DATA_WIDTH  read data from mem_ctrl.
- tx_done  in  1  completion from mem_ctrl.
- rd_valid  in  1  read valid from mem_ctrl.
- op  out  2  op to mem_ctrl.
- raw_address  out  ADDR_WIDTH  address to mem_ctrl.
- common_data_bus_read_in  out  DATA_WIDTH  write data to mem_ctrl.
- grant_id  out  $clog2(NUM_SRC)  current grantee index.
- busy  out  1  high in BUSY state.

Behaviour:
- FSM states:
  - IDLE -> BUSY when any op_src is non-NOP.
  - BUSY -> RELEASE on tx_done.
  - RELEASE -> IDLE unconditionally.
  - RELEASE masks stale requests while the source drops its op.
- Issue latency:
  - Winner is picked combinationally in IDLE.
  - At the next edge, grant_id, op, raw_address and write data are registered from the winner; busy = 1.
  - Request seen at cycle t: op is valid downstream at t+1.
- Held values: in BUSY, op/raw_address/common_data_bus_read_in stay at the latched values regardless of source changes. Sources must hold op until their tx_done.
- Completion routing:
  - tx_done_src[grant_id] = tx_done & busy; rd_valid_src[grant_id] = rd_valid & busy. Both combinational, zero latency.
  - All other bits are 0.
  - tx_done/rd_valid received outside BUSY are ignored.
  - Simultaneous rd_valid and tx_done are both forwarded.
- Read data: common_data_bus_write_out is replicated combinationally to every source slice.
- op is driven to NOP in the cycle tx_done is seen (registered, effective in RELEASE) and stays NOP in IDLE.
- Back-to-back: tx_done at cycle k; RELEASE at k+1; IDLE at k+2. Next op is valid downstream at k+3 at the earliest.
- Fixed-priority mode:
  - The lowest-index requester wins, unless aging applies.
  - Each source has an age counter, width $clog2(AGE_LIMIT+1). On each grant to another source while this source requests, it increments, saturating at AGE_LIMIT.
  - The counter clears when the source is granted or is not requesting in IDLE.
  - If any counter equals AGE_LIMIT, the lowest-index aged requester wins.
- Round-robin mode:
  - rr_ptr is the index one above the last grantee, modulo NUM_SRC.
  - Search starts at rr_ptr and wraps upward. rr_ptr updates on each grant.
  - Aging logic is unused.
- Reset (rst_n low at a clock edge, including mid-transaction):
  - State returns to IDLE; op = NOP; raw_address, write data and grant_id = 0; busy = 0.
  - rr_ptr = 0; age counters = 0.
  - The in-flight transaction is abandoned without a tx_done_src pulse.

Decomposition:
- mem_arb_pkg holds:
  - mem_op_t, 2-bit enum OP_NOP / OP_READ / OP_WRITE.
  - ARB_FIXED / ARB_RR constants.
  - the arb_state_t enum.
- One combinational sub-module, mem_arb_pick: takes the request vector, rr_ptr, the aged vector and mode, and returns a winner index and a valid flag.

Test Plan:
- Single read: src2 op=01, addr=0x6000_0040 at t0 -> op=01 and raw_address=0x6000_0040 at t0+1, grant_id=2. rd_valid+tx_done at t5 -> rd_valid_src=0100 and tx_done_src=0100 at t5; op=00 at t6.
- Fixed contention, AGE_LIMIT=0: src0 and src3 request continuously -> src0 granted every time. With AGE_LIMIT=2: src3 is granted after 2 src0 grants.
- Round-robin: all 4 request continuously -> grant order 0,1,2,3,0; each next op appears 3 cycles after the prior tx_done.
- Write with source change: src1 op=10, data=0xA5 (replicated); src1 changes its data during BUSY -> common_data_bus_read_in stays 0xA5 until tx_done.
- Stale/unsolicited completion: tx_done pulsed in IDLE -> tx_done_src=0, no state change. Stale op held during RELEASE is not re-granted.
- Reset mid-BUSY: rst_n=0 for one edge -> op=00, busy=0, grant_id=0, no tx_done_src pulse. A fresh request afterwards is granted from rr_ptr=0.
